// File: rtl/rv32i_regfile_if.sv
// Operand/write bus between issue logic and the integer register file.
// The master side is the issue/writeback logic and the slave side is the register file.
interface rv32i_regfile_if #(
    parameter int XPR_LEN    = 32,
    parameter int REG_ADDR_W = 5
) ();
    logic [REG_ADDR_W-1:0] ra1;
    logic [XPR_LEN-1:0]    rd1;
    logic [REG_ADDR_W-1:0] ra2;
    logic [XPR_LEN-1:0]    rd2;
    logic                  we;
    logic [REG_ADDR_W-1:0] wa;
    logic [XPR_LEN-1:0]    wd;
    logic                  busy_set;
    logic [REG_ADDR_W-1:0] busy_addr;
    logic                  rs1_ready;
    logic                  rs2_ready;

    modport master (
        output ra1, ra2, we, wa, wd, busy_set, busy_addr,
        input  rd1, rd2, rs1_ready, rs2_ready
    );

    modport slave (
        input  ra1, ra2, we, wa, wd, busy_set, busy_addr,
        output rd1, rd2, rs1_ready, rs2_ready
    );
endinterface

// File: rtl/rv32i_regfile.sv
// RV32I integer register file: two bypassed combinational read ports, one write port,
// and a per-register busy scoreboard that tracks pending long-latency writes.
module rv32i_regfile #(
    parameter int XPR_LEN    = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    rv32i_regfile_if.slave  rf
);
    localparam int NREGS = 2 ** REG_ADDR_W;

    logic [XPR_LEN-1:0] regs_reg [NREGS];
    logic [NREGS-1:0]   busy_reg;
    logic [NREGS-1:0]   busy_next;
    logic               wr_en;

    // x0 is never written, so its storage stays at its reset value of zero.
    assign wr_en = rf.we && (rf.wa != '0);

    // A new busy_set beats the clear from a retiring write to the same register.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == 0) begin : g_x0
                assign busy_next[gi] = 1'b0;
            end else begin : g_xn
                assign busy_next[gi] =
                    (rf.busy_set && (rf.busy_addr == REG_ADDR_W'(gi))) ||
                    (busy_reg[gi] && !(wr_en && (rf.wa == REG_ADDR_W'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
            if (wr_en) begin
                regs_reg[rf.wa] <= rf.wd;
            end
        end
    end

    assign rf.rd1 = (rf.ra1 == '0)                 ? '0    :
                    (wr_en && (rf.wa == rf.ra1))   ? rf.wd :
                                                     regs_reg[rf.ra1];
    assign rf.rd2 = (rf.ra2 == '0)                 ? '0    :
                    (wr_en && (rf.wa == rf.ra2))   ? rf.wd :
                                                     regs_reg[rf.ra2];

    // A write retiring this cycle satisfies the consumer even though busy is still set.
    assign rf.rs1_ready = (rf.ra1 == '0) || (wr_en && (rf.wa == rf.ra1)) || !busy_reg[rf.ra1];
    assign rf.rs2_ready = (rf.ra2 == '0) || (wr_en && (rf.wa == rf.ra2)) || !busy_reg[rf.ra2];
endmodule

// File: tb/tb_rv32i_regfile.sv
// Directed plus random checks of rv32i_regfile against an array-based reference model
// of the architectural registers and their pending-write flags.
module tb_rv32i_regfile;
    localparam int XPR_LEN    = 32;
    localparam int REG_ADDR_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    logic [31:0] mreg  [32];
    bit          mbusy [32];

    rv32i_regfile_if #(.XPR_LEN(XPR_LEN), .REG_ADDR_W(REG_ADDR_W)) rf_if ();

    rv32i_regfile #(.XPR_LEN(XPR_LEN), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            mreg[i]  = 32'h0;
            mbusy[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (rf_if.we && rf_if.wa == ra) return rf_if.wd;
        return mreg[ra];
    endfunction

    function automatic logic m_ready(input logic [4:0] ra);
        if (ra == 5'd0) return 1'b1;
        if (rf_if.we && rf_if.wa == ra) return 1'b1;
        return !mbusy[ra];
    endfunction

    task automatic apply(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic bs, input logic [4:0] ba,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        rf_if.we = w; rf_if.wa = a; rf_if.wd = d;
        rf_if.busy_set = bs; rf_if.busy_addr = ba;
        rf_if.ra1 = r1; rf_if.ra2 = r2;
        #1;
    endtask

    task automatic check_model(input string tag);
        step_no++;
        $display("step %0d %s we=%b wa=%0d wd=%h bs=%b ba=%0d ra1=%0d ra2=%0d rd1=%h rd2=%h rdy=%b%b",
                 step_no, tag, rf_if.we, rf_if.wa, rf_if.wd, rf_if.busy_set, rf_if.busy_addr,
                 rf_if.ra1, rf_if.ra2, rf_if.rd1, rf_if.rd2, rf_if.rs1_ready, rf_if.rs2_ready);
        chk({tag, ".rd1"}, rf_if.rd1, m_rd(rf_if.ra1));
        chk({tag, ".rd2"}, rf_if.rd2, m_rd(rf_if.ra2));
        chk({tag, ".rdy1"}, {31'b0, rf_if.rs1_ready}, {31'b0, m_ready(rf_if.ra1)});
        chk({tag, ".rdy2"}, {31'b0, rf_if.rs2_ready}, {31'b0, m_ready(rf_if.ra2)});
    endtask

    // Model update at the clock edge: a retiring write clears, a new busy_set then wins.
    task automatic commit();
        @(posedge clk);
        if (rf_if.we && rf_if.wa != 5'd0) begin
            mreg[rf_if.wa]  = rf_if.wd;
            mbusy[rf_if.wa] = 1'b0;
        end
        if (rf_if.busy_set && rf_if.busy_addr != 5'd0) mbusy[rf_if.busy_addr] = 1'b1;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        rf_if.we = 1'b0; rf_if.wa = '0; rf_if.wd = '0;
        rf_if.busy_set = 1'b0; rf_if.busy_addr = '0;
        rf_if.ra1 = '0; rf_if.ra2 = '0;
        m_reset();

        // Held in reset: every address reads zero and ready.
        for (int i = 0; i < 32; i++) begin
            rf_if.ra1 = 5'(i);
            rf_if.ra2 = 5'(31 - i);
            #1;
            chk($sformatf("rst.rd1[%0d]", i), rf_if.rd1, 32'h0);
            chk($sformatf("rst.rd2[%0d]", 31 - i), rf_if.rd2, 32'h0);
            chk($sformatf("rst.rdy1[%0d]", i), {31'b0, rf_if.rs1_ready}, 32'h1);
            chk($sformatf("rst.rdy2[%0d]", 31 - i), {31'b0, rf_if.rs2_ready}, 32'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd17, 5'd31); check_model("post_rst");
        chk("post_rst.rd1", rf_if.rd1, 32'h0);
        commit();

        // Write with same-cycle bypass, then registered read.
        apply(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0); check_model("wr5");
        chk("wr5.bypass", rf_if.rd1, 32'hDEADBEEF);
        commit();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5); check_model("rd5");
        chk("rd5.reg", rf_if.rd1, 32'hDEADBEEF);
        chk("rd5.same", rf_if.rd2, 32'hDEADBEEF);
        commit();

        // x0 protection for both data and scoreboard.
        apply(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0); check_model("x0_wr");
        chk("x0_wr.rd1", rf_if.rd1, 32'h0);
        commit();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0); check_model("x0_rd");
        chk("x0_rd.rd2", rf_if.rd2, 32'h0);
        chk("x0_rd.rdy1", {31'b0, rf_if.rs1_ready}, 32'h1);
        commit();

        // Scoreboard on x7: busy while idle, cleared by the retiring write.
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd7); check_model("bs7");
        commit();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7); check_model("wait7");
            chk("wait7.rdy2", {31'b0, rf_if.rs2_ready}, 32'h0);
            commit();
        end
        apply(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd7); check_model("ret7");
        chk("ret7.rdy2", {31'b0, rf_if.rs2_ready}, 32'h1);
        chk("ret7.rd2", rf_if.rd2, 32'h12345678);
        commit();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7); check_model("after7");
        chk("after7.rdy2", {31'b0, rf_if.rs2_ready}, 32'h1);
        commit();

        // Set/clear collision on x9: set wins, data still written.
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0); check_model("bs9");
        commit();
        apply(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 5'd9, 5'd0); check_model("coll9");
        commit();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0); check_model("post9");
        chk("post9.rdy1", {31'b0, rf_if.rs1_ready}, 32'h0);
        chk("post9.rd1", rf_if.rd1, 32'hA5A5A5A5);
        commit();

        // Randomized traffic concentrated on low registers to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            apply(1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                  ($urandom_range(0, 3) == 0), rnd_addr(), rnd_addr(), rnd_addr());
            check_model("rnd");
            commit();
        end

        // Asynchronous reset pulsed between clock edges with x4 pending.
        apply(1'b1, 5'd3, 32'h33333333, 1'b0, 5'd0, 5'd3, 5'd4); check_model("wr3");
        commit();
        apply(1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 5'd3, 5'd4); check_model("wr4");
        commit();
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4); check_model("bs4");
        commit();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4); check_model("pre_rst");
        chk("pre_rst.rd1", rf_if.rd1, 32'h33333333);
        chk("pre_rst.rdy2", {31'b0, rf_if.rs2_ready}, 32'h0);
        commit();
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("arst.rd1", rf_if.rd1, 32'h0);
        chk("arst.rd2", rf_if.rd2, 32'h0);
        chk("arst.rdy2", {31'b0, rf_if.rs2_ready}, 32'h1);
        #3;
        rst_n = 1'b1;
        #1;
        chk("arst_rel.rd1", rf_if.rd1, 32'h0);
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4); check_model("post_arst");
        chk("post_arst.rdy2", {31'b0, rf_if.rs2_ready}, 32'h1);
        commit();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv32i_regfile.md
Name: rv32i_regfile

Overview:
- Integer register file that sits directly upstream of rv32i_alu and supplies its in1/in2 operands.
- 32 x XPR_LEN architectural registers; two combinational read ports, one synchronous write port.
- Write-through bypass on both read ports.
- Per-register busy scoreboard so issue logic can hold an ALU operation until a pending long-latency write (load, multi-cycle op) retires.

Parameters:
- XPR_LEN, 32, data width of each register and of the read/write data ports.
- REG_ADDR_W, 5, register address width; register count = 2**REG_ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ra1  input  REG_ADDR_W  read address, port 1 (rs1).
- rd1  output  XPR_LEN  read data, port 1; drives ALU in1.
- ra2  input  REG_ADDR_W  read address, port 2 (rs2).
- rd2  output  XPR_LEN  read data, port 2; drives ALU in2.
- we  input  1  write enable.
- wa  input  REG_ADDR_W  write address.
- wd  input  XPR_LEN  write data; ALU out or load data.
- busy_set  input  1  mark register busy_addr as pending a future write.
- busy_addr  input  REG_ADDR_W  register to mark busy.
- rs1_ready  output  1  operand on port 1 is valid this cycle.
- rs2_ready  output  1  operand on port 2 is valid this cycle.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset:
  - Asserting rst_n low immediately clears all registers to 0 and all busy bits to 0.
  - With all registers 0 and no write active, rd1 = rd2 = 0 and rs1_ready = rs2_ready = 1 while in reset.
  - Reset mid-operation discards any pending busy state; no write occurs on the deasserting edge.
- x0:
  - Writes to address 0 are ignored; reads of address 0 return 0.
  - busy_set with busy_addr = 0 is ignored; x0 is always ready.
- Write: when we = 1 and wa != 0, reg[wa] <= wd on rising clk edge.
- Write latency: the written value is visible on a registered read the cycle after the edge. The bypass also makes it visible combinationally in the same cycle.
- Read (combinational, zero latency):
  - rdN = 0 if raN = 0.
  - Otherwise rdN = wd if we = 1 and wa = raN (bypass).
  - Otherwise rdN = reg[raN].
- Both ports may read the same address; both must return identical data.
- Scoreboard, busy[i] next-state per edge:
  - Set if busy_set = 1 and busy_addr = i != 0.
  - Else cleared if we = 1 and wa = i.
  - Else held.
- Simultaneous busy_set and we on the same address: set wins; busy stays 1 for the new pending write. The register data is still written.
- Ready (combinational):
  - rsN_ready = 1 if raN = 0.
  - Else 1 if we = 1 and wa = raN (retiring write bypassed this cycle).
  - Else ~busy[raN].
- busy_set on an already-busy register leaves it busy. This is not an error; one write clears it.
- No read/write collision hazard beyond the bypass rules; no stall output. Consumers gate issue on rsN_ready.
- Width rules: no sign extension or truncation; data passes through unmodified. Unknown high address bits are not possible since REG_ADDR_W fully decodes.

Test Plan:
- Reset check: hold rst_n = 0, sweep ra1/ra2 over 0..31 -> rd1 = rd2 = 0, rs1_ready = rs2_ready = 1. Release, read again -> still 0.
- Write/read: we = 1, wa = 5, wd = 32'hDEADBEEF, ra1 = 5 in the same cycle -> rd1 = 32'hDEADBEEF (bypass). Next cycle we = 0 -> rd1 = 32'hDEADBEEF.
- x0 protection: we = 1, wa = 0, wd = 32'hFFFFFFFF; busy_set = 1, busy_addr = 0; then ra1 = ra2 = 0 -> rd1 = rd2 = 0, rs1_ready = 1.
- Scoreboard: busy_set = 1, busy_addr = 7, then ra2 = 7 -> rs2_ready = 0 for 3 idle cycles. Write wa = 7, wd = 32'h12345678 -> rs2_ready = 1 and rd2 = 32'h12345678 in that cycle; rs2_ready stays 1 after.
- Set/clear collision: reg 9 busy; same cycle we = 1, wa = 9, wd = 32'hA5A5A5A5, busy_set = 1, busy_addr = 9 -> next cycle rs1_ready (ra1 = 9) = 0, rd1 = 32'hA5A5A5A5.
- Async reset mid-operation: regs 3 and 4 written and busy_set on 4 pending; pulse rst_n low between clock edges -> rd1 (ra1 = 3) = 0 immediately without a clock edge, rs2_ready (ra2 = 4) = 1.
